// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, default latencies.
package md_pkg;

  localparam int unsigned DATA_BIT    = 32;
  localparam int unsigned MULT_CYCLES = 5;
  localparam int unsigned DIV_CYCLES  = 10;

  // Request encodings on the op port; 3'b110 and 3'b111 are reserved.
  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  // Larger of two latencies, used to size the busy counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at acceptance and held in pending registers until
// the fixed-latency busy window expires, then committed to HI/LO.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned DataBit    = DATA_BIT,
  parameter int unsigned MultCycles = MULT_CYCLES,
  parameter int unsigned DivCycles  = DIV_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [DataBit-1:0] src_a,
  input  logic [DataBit-1:0] src_b,
  output logic               busy,
  output logic [DataBit-1:0] hi,
  output logic [DataBit-1:0] lo
);

  localparam int unsigned CntW  = $clog2(max_u(MultCycles, DivCycles) + 1);
  localparam int unsigned ProdW = 2 * DataBit;

  md_state_e          state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [DataBit-1:0] pend_hi_q, pend_hi_d;
  logic [DataBit-1:0] pend_lo_q, pend_lo_d;
  logic               pend_wr_q, pend_wr_d;
  logic [DataBit-1:0] hi_q, hi_d;
  logic [DataBit-1:0] lo_q, lo_d;
  logic               busy_q, busy_d;

  logic [ProdW-1:0]   mul_a, mul_b, prod;
  logic               div_signed, neg_a, neg_b, div_zero;
  logic [DataBit-1:0] mag_a, mag_b, dvsr, q_mag, r_mag, quot, rem;

  // Full-width product: operands extended to 2*DataBit so the truncated
  // product is exact for both signed and unsigned interpretation.
  always_comb begin
    if (op == MD_MULT) begin
      mul_a = {{DataBit{src_a[DataBit-1]}}, src_a};
      mul_b = {{DataBit{src_b[DataBit-1]}}, src_b};
    end else begin
      mul_a = {{DataBit{1'b0}}, src_a};
      mul_b = {{DataBit{1'b0}}, src_b};
    end
    prod = mul_a * mul_b;
  end

  // Sign-magnitude division: truncating quotient, remainder follows dividend.
  // The most-negative / -1 case falls out naturally as quotient 0x8000_0000.
  always_comb begin
    div_signed = (op == MD_DIV);
    neg_a      = div_signed & src_a[DataBit-1];
    neg_b      = div_signed & src_b[DataBit-1];
    mag_a      = neg_a ? (~src_a + DataBit'(1)) : src_a;
    mag_b      = neg_b ? (~src_b + DataBit'(1)) : src_b;
    div_zero   = (src_b == '0);
    dvsr       = div_zero ? DataBit'(1) : mag_b;
    q_mag      = mag_a / dvsr;
    r_mag      = mag_a % dvsr;
    quot       = (neg_a ^ neg_b) ? (~q_mag + DataBit'(1)) : q_mag;
    rem        = neg_a ? (~r_mag + DataBit'(1)) : r_mag;
  end

  // Next-state logic: accept requests in IDLE, count down and commit in RUN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    unique case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          case (op)
            MD_MULT, MD_MULTU: begin
              pend_hi_d = prod[ProdW-1:DataBit];
              pend_lo_d = prod[DataBit-1:0];
              pend_wr_d = 1'b1;
              cnt_d     = CntW'(MultCycles);
              busy_d    = 1'b1;
              state_d   = RUN;
            end
            MD_DIV, MD_DIVU: begin
              pend_hi_d = rem;
              pend_lo_d = quot;
              pend_wr_d = !div_zero;
              cnt_d     = CntW'(DivCycles);
              busy_d    = 1'b1;
              state_d   = RUN;
            end
            MD_MTHI: hi_d = src_a;
            MD_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == CntW'(1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus randomized requests
// compared against an arithmetic reference of HI/LO and busy latency.
module tb_md_unit;
  import md_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference product using native 64-bit arithmetic.
  function automatic logic [63:0] ref_mul(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    logic [63:0] up;
    if (o == 3'b000) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      return 64'(sp);
    end
    up = {32'h0, a} * {32'h0, b};
    return up;
  endfunction

  // Reference quotient/remainder using native int division semantics.
  task automatic ref_div(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    if (o == 3'b011) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one request at the next edge and verify latency and results.
  // noise: 0 quiet, 1 random requests while busy, 2 MTHI 0xAAAA while busy.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int noise);
    int n;
    int cycles;
    logic [31:0] q, r;
    logic [63:0] p;
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (o <= 3'b011) begin
      n = (o <= 3'b001) ? MULT_CYCLES : DIV_CYCLES;
      cycles = 0;
      while (busy === 1'b1 && cycles < 64) begin
        chk("hold_hi", 64'(hi), 64'(m_hi));
        chk("hold_lo", 64'(lo), 64'(m_lo));
        if (noise == 1) begin
          start = 1'($urandom_range(0, 1));
          op    = 3'($urandom_range(0, 7));
          src_a = $urandom;
          src_b = $urandom;
        end else if (noise == 2) begin
          start = 1'b1;
          op    = 3'b100;
          src_a = 32'h0000_AAAA;
        end
        @(posedge clk); #1;
        cycles++;
      end
      start = 1'b0;
      chk("busy_len", 64'(cycles), 64'(n));
      if (o <= 3'b001) begin
        p = ref_mul(o, a, b);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end else if (b != 32'h0) begin
        ref_div(o, a, b, q, r);
        m_hi = r;
        m_lo = q;
      end
    end else if (o == 3'b100) begin
      m_hi = a;
    end else if (o == 3'b101) begin
      m_lo = a;
    end
    chk("busy_idle", 64'(busy), 64'(0));
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
  endtask

  initial begin
    logic [2:0] o;
    rst_n = 1'b0; start = 1'b0; op = 3'b0; src_a = '0; src_b = '0;
    m_hi = '0; m_lo = '0;
    #3;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Multiply sign handling.
    run_op(3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFFE);
    run_op(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    chk("multu_hi", 64'(hi), 64'h0000_0001);
    chk("multu_lo", 64'(lo), 64'hFFFF_FFFE);

    // Division sign handling.
    run_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
    run_op(3'b011, 32'h7, 32'h2, 0);
    chk("divu_lo", 64'(lo), 64'h3);
    chk("divu_hi", 64'(hi), 64'h1);

    // Divide by zero leaves HI/LO untouched; overflow case.
    run_op(3'b100, 32'h1234, 32'h0, 0);
    run_op(3'b101, 32'h5678, 32'h0, 0);
    run_op(3'b010, 32'h9999, 32'h0, 0);
    chk("dz_hi", 64'(hi), 64'h1234);
    chk("dz_lo", 64'(lo), 64'h5678);
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("ovf_lo", 64'(lo), 64'h8000_0000);
    chk("ovf_hi", 64'(hi), 64'h0);

    // MTHI while busy is ignored; MTLO right after completion lands in one edge.
    run_op(3'b000, 32'h0000_0003, 32'h0000_0007, 2);
    chk("ign_hi", 64'(hi), 64'h0);
    run_op(3'b101, 32'h55, 32'h0, 0);
    chk("mtlo_lo", 64'(lo), 64'h55);

    // Back-to-back: MULT then DIV accepted in the first idle cycle.
    run_op(3'b001, 32'h0001_0000, 32'h0003_0000, 0);
    run_op(3'b011, 32'd100, 32'd7, 0);

    // Reserved ops change nothing.
    run_op(3'b110, 32'hDEAD_BEEF, 32'h1, 0);
    run_op(3'b111, 32'hDEAD_BEEF, 32'h1, 0);

    // Asynchronous reset in the middle of a MULT.
    run_op(3'b100, 32'h0000_1234, 32'h0, 0);
    op = 3'b000; src_a = 32'h7; src_b = 32'h9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_hi", 64'(hi), 64'(0));
    chk("arst_lo", 64'(lo), 64'(0));
    m_hi = '0; m_lo = '0;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_hi", 64'(hi), 64'(0));
    chk("post_rst_busy", 64'(busy), 64'(0));

    // Randomized requests with random noise while busy and random gaps.
    for (int i = 0; i < 300; i++) begin
      o = 3'($urandom_range(0, 7));
      run_op(o, pick_operand(), pick_operand(), int'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
